uart_rx_filtered: RTL

Noise-tolerant UART receiver (8N1, LSB first) that sits directly upstream of the comm command decoder. It synchronises the raw rx line and takes a 3-sample majority vote at each bit centre. Each good byte is delivered as a single-cycle rx_valid pulse with data. Framing errors and line breaks are reported separately, so the decoder never sees corrupted bytes.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_filtered_if.sv | 21 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx_filtered.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// majority-vote helper used by the receiver and by loopback checkers.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // True while a frame is being timed by the bit counter.
    function automatic logic in_frame(input uart_state_e st);
        return (st == START) || (st == DATA) || (st == STOP);
    endfunction

endpackage

// File: rtl/uart_rx_filtered_if.sv
// Receiver-side bundle: raw serial line in, decoded byte and status out.
interface uart_rx_filtered_if;
    import uart_pkg::*;

    logic                      rx_serial_line;
    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_frame_err;
    logic                      rx_break;
    logic                      busy;

    modport master (
        input  rx_serial_line,
        output rx_data, rx_valid, rx_frame_err, rx_break, busy
    );

    modport slave (
        output rx_serial_line,
        input  rx_data, rx_valid, rx_frame_err, rx_break, busy
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; resets to RST_VAL
// so an idle-high line does not look like activity straight out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1_r;
    logic s2_r;

    // Synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= RST_VAL;
            s2_r <= RST_VAL;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
        end
    end

    assign q = s2_r;
endmodule

// File: rtl/uart_rx_filtered.sv
// Noise-tolerant 8N1 UART receiver: synchronised line, 3-sample majority vote
// at each bit centre, good bytes as one-cycle pulses, framing/break reported apart.
module uart_rx_filtered
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    uart_rx_filtered_if.master rx_if
);
    localparam int MID   = CLK_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_S0    = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_S1    = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_VOTE  = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);
    localparam logic [UART_DATA_BITS-1:0] BYTE_ZERO = UART_DATA_BITS'(0);

    uart_state_e               state_r, state_s;
    logic                      line_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [IDX_W-1:0]          bit_idx_r;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic [1:0]                samp_r;
    logic                      at_vote_s, bit_end_s, vote_s;

    logic [UART_DATA_BITS-1:0] data_r, data_s;
    logic                      valid_r, valid_s;
    logic                      ferr_r, ferr_s;
    logic                      brk_r, brk_s;
    logic                      busy_r, busy_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_if.rx_serial_line),
        .q   (line_s)
    );

    assign at_vote_s = (cnt_r == CNT_VOTE);
    assign bit_end_s = (cnt_r == CNT_LAST);
    // Third sample is the live line value at MID+1.
    assign vote_s    = maj3(samp_r[0], samp_r[1], line_s);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= WAIT_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!line_s) state_s = START;
                else         state_s = IDLE;
            end
            START: begin
                if (at_vote_s && vote_s) state_s = IDLE;
                else if (bit_end_s)      state_s = DATA;
                else                     state_s = START;
            end
            DATA: begin
                if (bit_end_s && (bit_idx_r == IDX_LAST)) state_s = STOP;
                else                                      state_s = DATA;
            end
            STOP: begin
                // Leave at the vote, not the bit end, so a start bit that
                // follows with zero idle time is still caught on its edge.
                if (at_vote_s) state_s = vote_s ? IDLE : WAIT_IDLE;
                else           state_s = STOP;
            end
            WAIT_IDLE: begin
                if (line_s) state_s = IDLE;
                else        state_s = WAIT_IDLE;
            end
            default: state_s = WAIT_IDLE;
        endcase
    end

    // Bit timing, centre samples and data shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= IDX_ZERO;
            shift_r   <= BYTE_ZERO;
            samp_r    <= 2'b11;
        end else begin
            if (in_frame(state_r) && in_frame(state_s) && !bit_end_s) cnt_r <= cnt_r + CNT_ONE;
            else                                                      cnt_r <= CNT_ZERO;

            if (state_r != DATA)  bit_idx_r <= IDX_ZERO;
            else if (bit_end_s)   bit_idx_r <= bit_idx_r + IDX_ONE;
            else                  bit_idx_r <= bit_idx_r;

            if ((state_r == DATA) && at_vote_s) shift_r <= {vote_s, shift_r[UART_DATA_BITS-1:1]};
            else                                shift_r <= shift_r;

            if (in_frame(state_r) && (cnt_r == CNT_S0))      samp_r[0] <= line_s;
            else if (in_frame(state_r) && (cnt_r == CNT_S1)) samp_r[1] <= line_s;
            else                                             samp_r <= samp_r;
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        data_s  = data_r;
        valid_s = 1'b0;
        ferr_s  = 1'b0;
        brk_s   = brk_r;
        busy_s  = in_frame(state_s);
        case (state_r)
            STOP: begin
                if (at_vote_s) begin
                    if (vote_s) begin
                        data_s  = shift_r;
                        valid_s = 1'b1;
                    end else if (shift_r == BYTE_ZERO) begin
                        brk_s = 1'b1;
                    end else begin
                        ferr_s = 1'b1;
                    end
                end else begin
                    valid_s = 1'b0;
                end
            end
            WAIT_IDLE: begin
                if (line_s) brk_s = 1'b0;
                else        brk_s = brk_r;
            end
            default: begin
                valid_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= BYTE_ZERO;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            brk_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            data_r  <= data_s;
            valid_r <= valid_s;
            ferr_r  <= ferr_s;
            brk_r   <= brk_s;
            busy_r  <= busy_s;
        end
    end

    assign rx_if.rx_data      = data_r;
    assign rx_if.rx_valid     = valid_r;
    assign rx_if.rx_frame_err = ferr_r;
    assign rx_if.rx_break     = brk_r;
    assign rx_if.busy         = busy_r;
endmodule
